sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

Serial-in, parallel-out deserializer. It is the receiving end of the team's 4-bit parallel-in serial-out shift register link. It collects a strobed serial bit stream into WIDTH-bit words, tracks position with a bit counter, and hands each completed word to downstream logic through a valid/ready holding register. An overrun occurs when a word completes while the holding register is still occupied; that word is dropped and a sticky flag is raised.

## Interface
- WIDTH, 4, word width in bits; legal range 2..32
- MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1] (matches the PISO, which shifts out bit 3 first); 0: first bit lands in data_out[0]
- clk  input  1  sole clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush of the partial word and the overrun flag
- shift_en  input  1  serial_in is sampled on a rising edge only when this is high
- serial_in  input  1  serial data bit
- data_out  output  WIDTH  holding register contents
- data_valid  output  1  holding register holds an unconsumed word
- data_ready  input  1  downstream accepts the word
- bit_count  output  $clog2(WIDTH)  bits received in the current partial word, 0..WIDTH-1
- overrun  output  1  sticky; a completed word was dropped

## Operation
- Reset (rst_n low, asynchronous): shift register, bit_count, data_out, data_valid and overrun all go to 0 immediately. Any partial word is lost.
- Shift, when shift_en=1 and clear=0:
  - MSB_FIRST=1: shift register becomes {sr[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: shift register becomes {serial_in, sr[WIDTH-1:1]}.
  - bit_count increments.
- Word completion: a shift taken while bit_count == WIDTH-1.
  - bit_count wraps to 0.
  - The assembled word (including the current serial_in) is the completed word.
- Holding register update at a completion edge:
  - If data_valid=0, or data_valid=1 and data_ready=1: data_out takes the completed word and data_valid becomes 1.
  - Otherwise: the completed word is discarded, data_out is unchanged, and overrun becomes 1.
- Consume: data_valid=1 and data_ready=1 with no completion on that edge → data_valid becomes 0. data_out keeps its old value; it is don't-care once invalid but must not glitch.
- clear=1:
  - Shift register and bit_count go to 0, and overrun is cleared.
  - clear has priority over shift_en; the bit sampled on that edge is discarded.
  - The holding register and data_valid are unaffected, and a consume on the same edge still occurs.
- shift_en gaps of any length between bits are legal. State holds while shift_en=0.
- data_ready is ignored while data_valid=0.

## Timing
- Latency: data_valid and data_out update at the same rising edge that samples the last bit of a word. They are visible in the cycle after the last bit is presented.
- Throughput: one word per WIDTH shift_en cycles. Back-to-back words with shift_en held high are lossless if data_ready is high at each completion edge.
- Stability: data_out is stable while data_valid=1 and data_ready=0.
- Simultaneous consume and completion: data_valid stays 1 and data_out loads the new word on that edge. No overrun.
- overrun asserts at the dropping edge and remains 1 until clear or rst_n.
- bit_count is a registered output and reflects bits accepted through the previous edge.
- Reset deassertion needs no synchronizer inside the block; the integrator supplies a synchronously released rst_n.

## Test plan
- WIDTH=4, MSB_FIRST=1, data_ready=1, serial_in 1,0,1,1 on four consecutive shift_en cycles → data_out=4'hB and data_valid=1 for exactly one cycle, starting the cycle after the 4th bit. bit_count sequence is 1,2,3,0.
- data_ready=0, words 1011 then 0110 → data_out stays 4'hB. overrun=1 from the 8th-bit edge onward. Raising data_ready then drops data_valid one edge later.
- data_ready=0 through the first word and raised exactly on the 8th-bit edge of 1011, 0110 → data_out=4'h6, data_valid stays 1, overrun=0.
- Bits 1,1 then clear=1 with shift_en=1, then bits 0,1,1,0 → bit_count=0 after clear and data_out=4'h6. The bit sampled during clear is not included.
- rst_n pulsed low mid-word after 3 bits, with data_valid=1 → every output is 0 during reset without waiting for a clk edge. The next 4 bits, 1,1,1,1, produce 4'hF.
- MSB_FIRST=0, bits 1,0,0,0 with 2 idle cycles between each bit → data_out=4'h1. There is no valid pulse until the 4th bit, and overrun remains 0.

Source files
------------

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: strobed serial stream to WIDTH-bit words,
// handed off through a valid/ready holding register.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     shift_en,
  input  logic                     serial_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic             shift;
  logic             done;
  logic             accept;

  assign shift  = shift_en & ~clear;
  assign done   = shift & (bit_count == LAST);
  assign accept = ~data_valid | data_ready;

  always_comb begin
    sr_nxt = sr;
    if (MSB_FIRST) sr_nxt = {sr[WIDTH-2:0], serial_in};
    else           sr_nxt = {serial_in, sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (clear) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (shift) begin
      sr        <= sr_nxt;
      bit_count <= done ? '0 : bit_count + CW'(1);
    end
  end

  // A completion wins over a plain consume: the slot is refilled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (done && accept) begin
      data_out   <= sr_nxt;
      data_valid <= 1'b1;
    end else if (data_valid && data_ready && !done) begin
      data_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              overrun <= 1'b0;
    else if (clear)          overrun <= 1'b0;
    else if (done && !accept) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed scenarios plus randomized traffic
// against a queue-based word model, MSB-first and LSB-first instances.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       shift_en = 1'b0;
  logic       serial_in = 1'b0;
  logic       data_ready = 1'b0;

  logic [3:0] dm;
  logic       vm;
  logic [1:0] cm;
  logic       om;
  logic [3:0] dl;
  logic       vl;
  logic [1:0] cl;
  logic       ol;

  int total = 0;
  int passed = 0;

  bit         q[$];
  logic       m_valid;
  logic [3:0] m_dm;
  logic [3:0] m_dl;
  logic       m_ovr;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .shift_en(shift_en),
    .serial_in(serial_in), .data_out(dm), .data_valid(vm),
    .data_ready(data_ready), .bit_count(cm), .overrun(om)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .shift_en(shift_en),
    .serial_in(serial_in), .data_out(dl), .data_valid(vl),
    .data_ready(data_ready), .bit_count(cl), .overrun(ol)
  );

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_dm = 4'h0;
    m_dl = 4'h0;
    m_ovr = 1'b0;
  endtask

  // Word-level view: collect bits, place them by arrival order.
  task automatic model_edge();
    bit got;
    logic [3:0] wm;
    logic [3:0] wl;
    got = 1'b0;
    wm = 4'h0;
    wl = 4'h0;
    if (clear) begin
      q.delete();
      m_ovr = 1'b0;
    end else if (shift_en) begin
      q.push_back(serial_in);
      if (q.size() == 4) begin
        for (int i = 0; i < 4; i++) begin
          wm[3-i] = q[i];
          wl[i] = q[i];
        end
        q.delete();
        got = 1'b1;
      end
    end
    if (got) begin
      if (!m_valid || data_ready) begin
        m_valid = 1'b1;
        m_dm = wm;
        m_dl = wl;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && data_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    shift_en = 1'b1;
    serial_in = b;
    tick();
    shift_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    total++;
    if ({dm, vm, cm, om} !== 8'h00)
      $display("FAIL reset_msb got %h want 00", {dm, vm, cm, om});
    else passed++;
    total++;
    if ({dl, vl, cl, ol} !== 8'h00)
      $display("FAIL reset_lsb got %h want 00", {dl, vl, cl, ol});
    else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] bits;
    logic [1:0] exp_cnt;
    bits = 4'b1011;
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(bits[3-i]);
      exp_cnt = 2'(i + 1);
      total++;
      if (cm !== exp_cnt)
        $display("FAIL basic_count got %0d want %0d", cm, exp_cnt);
      else passed++;
      if (i < 3) begin
        total++;
        if (vm !== 1'b0)
          $display("FAIL basic_early_valid got %b want 0", vm);
        else passed++;
      end
    end
    total++;
    if (vm !== 1'b1 || dm !== 4'hB)
      $display("FAIL basic_word got %b/%h want 1/b", vm, dm);
    else passed++;
    total++;
    if (vl !== 1'b1 || dl !== 4'hD)
      $display("FAIL basic_word_lsb got %b/%h want 1/d", vl, dl);
    else passed++;
    tick();
    total++;
    if (vm !== 1'b0)
      $display("FAIL basic_pulse got %b want 0", vm);
    else passed++;
  endtask

  task automatic test_overrun();
    logic [7:0] bits;
    bits = 8'b1011_0110;
    data_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(bits[7-i]);
      if (i == 3) begin
        total++;
        if (om !== 1'b0 || dm !== 4'hB)
          $display("FAIL ovr_first got %b/%h want 0/b", om, dm);
        else passed++;
      end
    end
    total++;
    if (om !== 1'b1 || dm !== 4'hB || vm !== 1'b1)
      $display("FAIL ovr_drop got %b/%h/%b want 1/b/1", om, dm, vm);
    else passed++;
    data_ready = 1'b1;
    tick();
    total++;
    if (vm !== 1'b0 || om !== 1'b1)
      $display("FAIL ovr_consume got %b/%b want 0/1", vm, om);
    else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (om !== 1'b0)
      $display("FAIL ovr_clear got %b want 0", om);
    else passed++;
  endtask

  task automatic test_simul();
    logic [7:0] bits;
    bits = 8'b1011_0110;
    data_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) data_ready = 1'b1;
      send(bits[7-i]);
    end
    total++;
    if (dm !== 4'h6 || vm !== 1'b1 || om !== 1'b0)
      $display("FAIL simul got %h/%b/%b want 6/1/0", dm, vm, om);
    else passed++;
    tick();
  endtask

  task automatic test_clear();
    logic [3:0] bits;
    bits = 4'b0110;
    data_ready = 1'b1;
    send(1'b1);
    send(1'b1);
    clear = 1'b1;
    send(1'b1);
    clear = 1'b0;
    total++;
    if (cm !== 2'd0)
      $display("FAIL clear_count got %0d want 0", cm);
    else passed++;
    for (int i = 0; i < 4; i++) send(bits[3-i]);
    total++;
    if (dm !== 4'h6 || vm !== 1'b1)
      $display("FAIL clear_word got %h/%b want 6/1", dm, vm);
    else passed++;
    tick();
  endtask

  task automatic test_async_reset();
    logic [3:0] bits;
    bits = 4'b1010;
    data_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(bits[3-i]);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    total++;
    if (vm !== 1'b1 || cm !== 2'd3)
      $display("FAIL pre_reset got %b/%0d want 1/3", vm, cm);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({dm, vm, cm, om} !== 8'h00 || {dl, vl, cl, ol} !== 8'h00)
      $display("FAIL async_reset got %h/%h want 00/00",
               {dm, vm, cm, om}, {dl, vl, cl, ol});
    else passed++;
    model_reset();
    #1;
    rst_n = 1'b1;
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b1);
    total++;
    if (dm !== 4'hF || vm !== 1'b1)
      $display("FAIL post_reset got %h/%b want f/1", dm, vm);
    else passed++;
    tick();
  endtask

  task automatic test_lsb_gaps();
    logic [3:0] bits;
    logic early;
    bits = 4'b1000;
    early = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(bits[3-i]);
      if (i < 3 && vl !== 1'b0) early = 1'b1;
      if (i < 3) begin
        tick();
        if (vl !== 1'b0) early = 1'b1;
        tick();
        if (vl !== 1'b0) early = 1'b1;
      end
    end
    total++;
    if (early !== 1'b0)
      $display("FAIL gaps_early got %b want 0", early);
    else passed++;
    total++;
    if (dl !== 4'h1 || vl !== 1'b1 || ol !== 1'b0)
      $display("FAIL gaps_word got %h/%b/%b want 1/1/0", dl, vl, ol);
    else passed++;
    tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      shift_en = ($urandom_range(0, 3) != 0);
      serial_in = 1'($urandom);
      data_ready = ($urandom_range(0, 2) != 0);
      clear = ($urandom_range(0, 19) == 0);
      tick();
      total++;
      if (vm !== m_valid || om !== m_ovr ||
          cm !== 2'(q.size()) || (m_valid && dm !== m_dm)) begin
        if (errs < 10)
          $display("FAIL rand_msb cyc %0d got %b/%b/%0d/%h want %b/%b/%0d/%h",
                   n, vm, om, cm, dm, m_valid, m_ovr, q.size(), m_dm);
        errs++;
      end else passed++;
      total++;
      if (vl !== m_valid || ol !== m_ovr ||
          cl !== 2'(q.size()) || (m_valid && dl !== m_dl)) begin
        if (errs < 10)
          $display("FAIL rand_lsb cyc %0d got %b/%b/%0d/%h want %b/%b/%0d/%h",
                   n, vl, ol, cl, dl, m_valid, m_ovr, q.size(), m_dl);
        errs++;
      end else passed++;
    end
    clear = 1'b0;
    shift_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_simul();
    test_clear();
    test_async_reset();
    test_lsb_gaps();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
